// File: rtl/sm4_key_expand.sv
// SM4 key-schedule engine: expands a 128-bit master key into rk0..rk31 and serves
// them through a registered read port ordered for encryption or decryption.
module sm4_key_expand #(
    parameter int ROUNDS_PER_CLK = 1,
    parameter int DLY            = 1
) (
    input  logic         r_clk,
    input  logic         r_rst,
    input  logic         i_key_en,
    input  logic [127:0] i_key,
    input  logic         i_flag,
    input  logic [4:0]   i_rk_idx,
    output logic [31:0]  o_rk,
    output logic         o_busy,
    output logic         o_key_ok
);

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam logic [4:0] CNT_STEP = 5'(ROUNDS_PER_CLK);
    localparam logic [4:0] LAST_CNT = 5'(32 - ROUNDS_PER_CLK);

    // DLY is kept for harness compatibility only; the logic itself is zero-delay.
    if (!(ROUNDS_PER_CLK == 1 || ROUNDS_PER_CLK == 2 || ROUNDS_PER_CLK == 4) || DLY < 0) begin : g_bad_param
        $error("sm4_key_expand: ROUNDS_PER_CLK must be 1, 2 or 4 and DLY non-negative");
    end

    typedef enum logic {IDLE, EXPAND} state_t;
    typedef logic [ROUNDS_PER_CLK+3:0][31:0] win_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] rk_mem [32];
    win_t        win;

    function automatic logic [31:0] tau(input logic [31:0] a);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) begin
            b[8*j +: 8] = SBOX[a[8*j +: 8]];
        end
        return b;
    endfunction

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    // CK byte j of round i is 7*(4i+j) mod 256; the 8-bit product wraps naturally.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [7:0]  base;
        logic [31:0] w;
        base = {1'b0, i, 2'b00};
        for (int j = 0; j < 4; j++) begin
            w[31-8*j -: 8] = (base + 8'(j)) * 8'd7;
        end
        return w;
    endfunction

    function automatic win_t expand_rounds(input logic [31:0] a0, a1, a2, a3, input logic [4:0] base);
        win_t w;
        w[0] = a0;
        w[1] = a1;
        w[2] = a2;
        w[3] = a3;
        for (int r = 0; r < ROUNDS_PER_CLK; r++) begin
            w[r+4] = w[r] ^ l_prime(tau(w[r+1] ^ w[r+2] ^ w[r+3] ^ ck_word(base + 5'(r))));
        end
        return w;
    endfunction

    assign win = expand_rounds(k0, k1, k2, k3, cnt);

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            k0       <= '0;
            k1       <= '0;
            k2       <= '0;
            k3       <= '0;
            o_rk     <= '0;
            o_busy   <= 1'b0;
            o_key_ok <= 1'b0;
        end else begin
            o_rk <= i_flag ? rk_mem[i_rk_idx] : rk_mem[5'd31 - i_rk_idx];
            // A strobe always wins, so a strobe during expansion restarts from the new key.
            if (i_key_en) begin
                k0       <= i_key[31:0]   ^ FK0;
                k1       <= i_key[63:32]  ^ FK1;
                k2       <= i_key[95:64]  ^ FK2;
                k3       <= i_key[127:96] ^ FK3;
                cnt      <= '0;
                state    <= EXPAND;
                o_busy   <= 1'b1;
                o_key_ok <= 1'b0;
            end else if (state == EXPAND) begin
                k0  <= win[ROUNDS_PER_CLK];
                k1  <= win[ROUNDS_PER_CLK+1];
                k2  <= win[ROUNDS_PER_CLK+2];
                k3  <= win[ROUNDS_PER_CLK+3];
                cnt <= cnt + CNT_STEP;
                if (cnt == LAST_CNT) begin
                    state    <= IDLE;
                    o_busy   <= 1'b0;
                    o_key_ok <= 1'b1;
                end
            end
        end
    end

    // Round-key storage carries no reset; it is only meaningful once o_key_ok is set.
    always_ff @(posedge r_clk) begin
        if (state == EXPAND && !i_key_en) begin
            for (int r = 0; r < ROUNDS_PER_CLK; r++) begin
                rk_mem[cnt + 5'(r)] <= win[r+4];
            end
        end
    end

endmodule

// File: tb/tb_sm4_key_expand.sv
// Bench for sm4_key_expand: three instances (1, 2, 4 rounds per clock) share the same
// stimulus; read results are checked against a scoreboard fed by an independent model.
module tb_sm4_key_expand;

    localparam bit [2047:0] SBT = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    localparam logic [127:0] KEY1 = 128'h76543210_FEDCBA98_89ABCDEF_01234567;
    localparam logic [127:0] KEYA = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    localparam logic [127:0] KEYB = 128'hDEADBEEF_01020304_CAFEF00D_55AA55AA;

    logic         r_clk = 1'b0;
    logic         r_rst;
    logic         i_key_en;
    logic [127:0] i_key;
    logic         i_flag;
    logic [4:0]   i_rk_idx;
    logic [31:0]  o_rk_w     [3];
    logic         o_busy_w   [3];
    logic         o_key_ok_w [3];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [31:0] exp_rk [32];

    always #5 r_clk = ~r_clk;

    sm4_key_expand #(.ROUNDS_PER_CLK(1)) u_r1 (
        .r_clk(r_clk), .r_rst(r_rst), .i_key_en(i_key_en), .i_key(i_key), .i_flag(i_flag),
        .i_rk_idx(i_rk_idx), .o_rk(o_rk_w[0]), .o_busy(o_busy_w[0]), .o_key_ok(o_key_ok_w[0]));
    sm4_key_expand #(.ROUNDS_PER_CLK(2)) u_r2 (
        .r_clk(r_clk), .r_rst(r_rst), .i_key_en(i_key_en), .i_key(i_key), .i_flag(i_flag),
        .i_rk_idx(i_rk_idx), .o_rk(o_rk_w[1]), .o_busy(o_busy_w[1]), .o_key_ok(o_key_ok_w[1]));
    sm4_key_expand #(.ROUNDS_PER_CLK(4)) u_r4 (
        .r_clk(r_clk), .r_rst(r_rst), .i_key_en(i_key_en), .i_key(i_key), .i_flag(i_flag),
        .i_rk_idx(i_rk_idx), .o_rk(o_rk_w[2]), .o_busy(o_busy_w[2]), .o_key_ok(o_key_ok_w[2]));

    function automatic logic [7:0] tb_sbox(input logic [7:0] a);
        return SBT[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [31:0] tb_t(input logic [31:0] x);
        logic [31:0] y;
        y = {tb_sbox(x[31:24]), tb_sbox(x[23:16]), tb_sbox(x[15:8]), tb_sbox(x[7:0])};
        return y ^ {y[18:0], y[31:19]} ^ {y[8:0], y[31:9]};
    endfunction

    function automatic logic [31:0] tb_ck(input int i);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            w = {w[23:0], 8'((7 * (4*i + j)) % 256)};
        end
        return w;
    endfunction

    task automatic model(input logic [127:0] key);
        logic [31:0] k [36];
        k[0] = key[31:0]   ^ 32'hA3B1BAC6;
        k[1] = key[63:32]  ^ 32'h56AA3350;
        k[2] = key[95:64]  ^ 32'h677D9197;
        k[3] = key[127:96] ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            k[i+4] = k[i] ^ tb_t(k[i+1] ^ k[i+2] ^ k[i+3] ^ tb_ck(i));
            exp_rk[i] = k[i+4];
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic busy_exp, input logic ok_exp);
        for (int n = 0; n < 3; n++) begin
            check1($sformatf("%s busy u%0d", tag, n), o_busy_w[n], busy_exp);
            check1($sformatf("%s key_ok u%0d", tag, n), o_key_ok_w[n], ok_exp);
        end
    endtask

    // Caller sits at a negedge; the read is sampled on the next rising edge.
    task automatic issue_read(input logic flag, input logic [4:0] idx, input logic [31:0] exp, input string tag);
        i_flag   = flag;
        i_rk_idx = idx;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic drain_one();
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        for (int n = 0; n < 3; n++) begin
            check32($sformatf("%s u%0d", t, n), o_rk_w[n], e);
        end
    endtask

    task automatic read_one(input logic flag, input logic [4:0] idx, input logic [31:0] exp, input string tag);
        issue_read(flag, idx, exp, tag);
        @(negedge r_clk);
        drain_one();
    endtask

    task automatic sweep(input logic flag, input string tag);
        for (int idx = 0; idx < 32; idx++) begin
            issue_read(flag, 5'(idx), flag ? exp_rk[idx] : exp_rk[31-idx], $sformatf("%s idx%0d", tag, idx));
            @(negedge r_clk);
            drain_one();
        end
    endtask

    // Caller sits at a negedge; the strobe is sampled on the next rising edge.
    task automatic strobe(input logic [127:0] key);
        i_key    = key;
        i_key_en = 1'b1;
        @(negedge r_clk);
        i_key_en = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat [3];
        lat = '{-1, -1, -1};
        for (int c = 1; c <= 40; c++) begin
            @(negedge r_clk);
            for (int n = 0; n < 3; n++) begin
                if (lat[n] < 0 && o_key_ok_w[n] === 1'b1) lat[n] = c;
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        check_int({tag, " latency r1"}, lat[0], 32);
        check_int({tag, " latency r2"}, lat[1], 16);
        check_int({tag, " latency r4"}, lat[2], 8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rkey;
        logic [4:0]   ridx;
        int           seen_ok;
        int           seen_busy;

        r_rst    = 1'b1;
        i_key_en = 1'b0;
        i_key    = '0;
        i_flag   = 1'b1;
        i_rk_idx = '0;
        repeat (3) @(negedge r_clk);
        check_ctrl("reset", 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) check32($sformatf("reset o_rk u%0d", n), o_rk_w[n], 32'h0);
        r_rst = 1'b0;
        @(negedge r_clk);

        // T1/T2/T5: standard test key on all three unroll factors
        model(KEY1);
        strobe(KEY1);
        check_ctrl("t1 after strobe", 1'b1, 1'b0);
        wait_done("t1");
        check1("t1 done busy r1", o_busy_w[0], 1'b0);
        read_one(1'b1, 5'd0,  32'hF12186F9, "t1 enc idx0");
        read_one(1'b1, 5'd31, 32'h9124A012, "t1 enc idx31");
        read_one(1'b0, 5'd0,  32'h9124A012, "t2 dec idx0");
        read_one(1'b0, 5'd31, 32'hF12186F9, "t2 dec idx31");
        sweep(1'b1, "t2 enc");
        sweep(1'b0, "t2 dec");
        check_ctrl("t2 hold", 1'b0, 1'b1);

        // T3: restart mid-expansion with a second key
        strobe(KEYA);
        repeat (9) @(negedge r_clk);
        model(KEYB);
        strobe(KEYB);
        check_ctrl("t3 after restart", 1'b1, 1'b0);
        wait_done("t3");
        sweep(1'b1, "t3 enc");

        // T4: asynchronous reset in the middle of an expansion
        strobe(KEYA);
        repeat (14) @(negedge r_clk);
        @(posedge r_clk);
        #2;
        r_rst = 1'b1;
        #1;
        check_ctrl("t4 in reset", 1'b0, 1'b0);
        for (int n = 0; n < 3; n++) check32($sformatf("t4 o_rk u%0d", n), o_rk_w[n], 32'h0);
        @(negedge r_clk);
        r_rst = 1'b0;
        seen_ok   = 0;
        seen_busy = 0;
        repeat (100) begin
            @(negedge r_clk);
            for (int n = 0; n < 3; n++) begin
                if (o_key_ok_w[n] !== 1'b0) seen_ok++;
                if (o_busy_w[n] !== 1'b0) seen_busy++;
            end
        end
        check_int("t4 key_ok after release", seen_ok, 0);
        check_int("t4 busy after release", seen_busy, 0);

        // T6: random keys back to back, each strobed one clock after completion
        rkey = {$urandom, $urandom, $urandom, $urandom};
        model(rkey);
        strobe(rkey);
        for (int k = 0; k < 8; k++) begin
            wait_done($sformatf("t6 key%0d", k));
            if (k < 7) begin
                ridx = 5'($urandom_range(0, 31));
                issue_read(1'b1, ridx, exp_rk[ridx], $sformatf("t6 key%0d window idx%0d", k, ridx));
                rkey = {$urandom, $urandom, $urandom, $urandom};
                model(rkey);
                strobe(rkey);
                drain_one();
            end
        end
        sweep(1'b1, "t6 enc");
        sweep(1'b0, "t6 dec");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
